// File: rtl/conv_enc_framer_213.sv
// Rate-1/2, memory-3 convolutional encoder with zero-tail framing.
// Groups L accepted bits into a sequence, appends 3 tail symbols, then idles GAP cycles.
module conv_enc_framer_213 #(
   parameter int unsigned L   = 16,
   parameter int unsigned GAP = 2,
   parameter logic [3:0]  G0  = 4'b1111,
   parameter logic [3:0]  G1  = 4'b1101
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [1:0] Rx,
   output logic       rx_valid,
   output logic       seq_ready,
   output logic       busy
);

   localparam int unsigned CW = $clog2(L + 1);
   localparam int unsigned GW = 8;
   localparam logic [CW-1:0] BIT_LAST = CW'(L - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL, ST_GAP} state_t;

   state_t        state;
   logic [2:0]    s;
   logic [CW-1:0] bit_cnt;
   logic [1:0]    tail_cnt;
   logic [GW-1:0] gap_cnt;

   // s[0] is the most recent bit; the MSB of each generator taps the incoming bit
   function automatic logic [1:0] encode(input logic b, input logic [2:0] st);
      logic [3:0] u;
      u = {b, st[0], st[1], st[2]};
      return {^(u & G0), ^(u & G1)};
   endfunction

   // Gated by reset so the source sees no acceptance window while reset is held
   always_comb din_ready = ~reset & ((state == ST_IDLE) | (state == ST_DATA));
   always_comb busy      = (state != ST_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         s         <= '0;
         bit_cnt   <= '0;
         tail_cnt  <= '0;
         gap_cnt   <= '0;
         Rx        <= '0;
         rx_valid  <= 1'b0;
         seq_ready <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         seq_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (din_valid) begin
                  Rx        <= encode(din, s);
                  rx_valid  <= 1'b1;
                  seq_ready <= 1'b1;
                  s         <= {s[1:0], din};
                  bit_cnt   <= CW'(1);
                  tail_cnt  <= '0;
                  state     <= (L == 1) ? ST_TAIL : ST_DATA;
               end
            end
            ST_DATA: begin
               if (din_valid) begin
                  Rx       <= encode(din, s);
                  rx_valid <= 1'b1;
                  s        <= {s[1:0], din};
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) state <= ST_TAIL;
               end
            end
            ST_TAIL: begin
               Rx       <= encode(1'b0, s);
               rx_valid <= 1'b1;
               s        <= {s[1:0], 1'b0};
               tail_cnt <= tail_cnt + 1'b1;
               if (tail_cnt == 2'd2) begin
                  tail_cnt <= '0;
                  bit_cnt  <= '0;
                  if (GAP == 0) begin
                     state <= ST_IDLE;
                  end else begin
                     state   <= ST_GAP;
                     gap_cnt <= '0;
                     s       <= '0;
                  end
               end
            end
            ST_GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_enc_framer_213.sv
// Scoreboard bench for conv_enc_framer_213: directed framing cases plus random sequences
// checked against a convolution-sum reference model.
module tb_conv_enc_framer_213;

   localparam int unsigned L   = 4;
   localparam int unsigned GAP = 2;
   localparam logic [3:0]  G0  = 4'b1111;
   localparam logic [3:0]  G1  = 4'b1101;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic [1:0] Rx;
   logic       rx_valid;
   logic       seq_ready;
   logic       busy;

   conv_enc_framer_213 #(.L(L), .GAP(GAP), .G0(G0), .G1(G1)) dut (
      .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .Rx(Rx), .rx_valid(rx_valid),
      .seq_ready(seq_ready), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] sym;
      logic       first;
   } exp_t;

   exp_t        exp_q[$];
   logic [1:0]  obs_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned n_bubble = 0;
   int          nbits = 0;
   logic        seq_bits [0:L-1];
   logic [1:0]  basic_exp [0:6] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
   logic [1:0]  zero_exp  [0:6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   // Information bit j of the current sequence; zero outside the data span (start state and tail)
   function automatic logic bit_at(input int j);
      if (j < 0 || j >= int'(L)) return 1'b0;
      return seq_bits[j];
   endfunction

   // Symbol k = modulo-2 convolution of the bit stream with each generator
   function automatic logic [1:0] ref_sym(input int k);
      logic r1, r0;
      r1 = 1'b0;
      r0 = 1'b0;
      for (int t = 0; t < 4; t++) begin
         r1 ^= G0[3-t] & bit_at(k - t);
         r0 ^= G1[3-t] & bit_at(k - t);
      end
      return {r1, r0};
   endfunction

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic send_bit(input logic b, output int waited);
      exp_t e;
      waited = 0;
      din = b;
      din_valid = 1'b1;
      while (!din_ready && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      if (!din_ready) begin
         check("ready_timeout", din_ready, 1);
         din_valid = 1'b0;
         return;
      end
      seq_bits[nbits] = b;
      e.sym = ref_sym(nbits);
      e.first = (nbits == 0);
      exp_q.push_back(e);
      nbits++;
      if (nbits == int'(L)) begin
         for (int k = int'(L); k < int'(L) + 3; k++) begin
            e.sym = ref_sym(k);
            e.first = 1'b0;
            exp_q.push_back(e);
         end
         nbits = 0;
      end
      @(negedge clock);
      din_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic check_obs(input string name, input logic [1:0] want [0:6]);
      logic [1:0] got;
      for (int i = 0; i < 7; i++) begin
         got = 2'bxx;
         if (obs_q.size() > 0) got = obs_q.pop_front();
         check(name, got, want[i]);
      end
   endtask

   task automatic check_reset_outputs();
      check("reset_Rx", Rx, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_seq_ready", seq_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_din_ready", din_ready, 0);
   endtask

   // Monitor: pops the scoreboard on every presented symbol
   initial begin
      exp_t e;
      logic [1:0] prev_rx;
      prev_rx = '0;
      forever begin
         @(posedge clock);
         #2;
         if (reset) begin
            prev_rx = '0;
         end else begin
            if (rx_valid) begin
               obs_q.push_back(Rx);
               if (exp_q.size() == 0) begin
                  check("unexpected_symbol", rx_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("rx_symbol", Rx, e.sym);
                  check("seq_ready", seq_ready, e.first);
               end
            end else begin
               check("seq_ready_no_valid", seq_ready, 0);
               check("rx_hold", Rx, prev_rx);
               if (busy && din_ready) n_bubble++;
            end
            if (!din_ready) check("busy_when_not_ready", busy, 1);
            prev_rx = Rx;
         end
      end
   end

   initial begin
      int w;
      #1 reset = 1'b1;
      #1 check_reset_outputs();
      @(negedge clock);
      reset = 1'b0;
      #1 check("ready_after_reset", din_ready, 1);
      @(negedge clock);

      // Basic encode, then measure the not-ready window before the next sequence
      obs_q.delete();
      send_bit(1'b1, w); send_bit(1'b0, w); send_bit(1'b1, w); send_bit(1'b1, w);
      send_bit(1'b1, w);
      check("ready_low_cycles", w, 5);
      check_obs("basic_sym", basic_exp);

      // Stall: same bits, din_valid dropped for 2 cycles after the second bit
      n_bubble = 0;
      send_bit(1'b0, w);
      idle(2);
      send_bit(1'b1, w); send_bit(1'b1, w);
      idle(6);
      check("stall_bubbles", n_bubble, 2);
      check_obs("stall_sym", basic_exp);
      check("stall_obs_extra", obs_q.size(), 0);

      // All-zero sequence
      send_bit(1'b0, w); send_bit(1'b0, w); send_bit(1'b0, w); send_bit(1'b0, w);
      idle(6);
      check_obs("zero_sym", zero_exp);
      check("zero_obs_extra", obs_q.size(), 0);
      check("idle_after_zero", busy, 0);

      // Reset mid-DATA after 2 bits
      send_bit(1'b1, w); send_bit(1'b0, w);
      #1 reset = 1'b1;
      #1 check_reset_outputs();
      exp_q.delete();
      nbits = 0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      obs_q.delete();
      send_bit(1'b1, w); send_bit(1'b0, w); send_bit(1'b1, w); send_bit(1'b1, w);
      idle(6);
      check_obs("post_reset_sym", basic_exp);

      // Random sequences with random stalls
      for (int sq = 0; sq < 200; sq++) begin
         for (int i = 0; i < int'(L); i++) begin
            if ($urandom_range(3) == 0) idle(int'($urandom_range(3, 1)));
            send_bit(1'($urandom_range(1)), w);
         end
         if ($urandom_range(4) == 0) idle(int'($urandom_range(10, 1)));
      end

      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clock);
         w++;
      end
      check("drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
